// File: rtl/multiport_reg_file_pkg.sv
// Shared constants for the multiport register file: parameter defaults and
// the hex-to-seven-segment pattern table.
package multiport_reg_file_pkg;

  localparam int unsigned DefaultDataW   = 8;
  localparam int unsigned DefaultDepth   = 8;
  localparam int unsigned DefaultScanDiv = 16;

  // Active-high segment patterns, bit 6 = a ... bit 0 = g, indexed by nibble.
  localparam logic [15:0][6:0] SegTable = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // Number of hex digits needed to show a word of the given width.
  function automatic int unsigned num_digits(input int unsigned width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/multiport_reg_file_hex7seg.sv
// Hex nibble to active-low seven-segment decoder.
module hex7seg
  import multiport_reg_file_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Table lookup, inverted for common-anode pins.
  always_comb begin
    o_seg = ~SegTable[i_nib];
  end

endmodule

// File: rtl/multiport_reg_file.sv
// One-write, two-read register file with registered read ports, write-to-read
// bypass, and a multiplexed hex display of read port A.
module multiport_reg_file
  import multiport_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned DEPTH    = DefaultDepth,
  parameter int unsigned SCAN_DIV = DefaultScanDiv
) (
  input  logic                         i_ck,
  input  logic                         i_rst,
  input  logic                         i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_rd_en_a,
  input  logic                         i_rd_en_b,
  input  logic [$clog2(DEPTH)-1:0]     i_rd_addr_a,
  input  logic [$clog2(DEPTH)-1:0]     i_rd_addr_b,
  output logic [DATA_W-1:0]            o_rd_data_a,
  output logic [DATA_W-1:0]            o_rd_data_b,
  output logic                         o_rd_vld_a,
  output logic                         o_rd_vld_b,
  output logic [6:0]                   o_seg,
  output logic [num_digits(DATA_W)-1:0] o_an
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned DIGITS  = num_digits(DATA_W);
  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
  // Keep the digit index at least one bit wide for single-digit words.
  localparam int unsigned DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRESC_W-1:0] PrescMax = PRESC_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]   DigMax   = DIG_W'(DIGITS - 1);

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rd_data_a;
  logic [DATA_W-1:0]   r_rd_data_b;
  logic                r_rd_vld_a;
  logic                r_rd_vld_b;
  logic [PRESC_W-1:0]  r_presc;
  logic [DIG_W-1:0]    r_dig;

  logic                w_byp_a;
  logic                w_byp_b;
  logic [DATA_W-1:0]   w_rd_word_a;
  logic [DATA_W-1:0]   w_rd_word_b;
  logic [4*DIGITS-1:0] w_disp;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_an;
  logic [ADDR_W-1:0]   w_unused_addr;

  assign w_unused_addr = i_wr_addr;

  // A read of the address being written this edge returns the new data.
  assign w_byp_a     = i_wr_en && (i_wr_addr == i_rd_addr_a);
  assign w_byp_b     = i_wr_en && (i_wr_addr == i_rd_addr_b);
  assign w_rd_word_a = w_byp_a ? i_wr_data : r_mem[i_rd_addr_a];
  assign w_rd_word_b = w_byp_b ? i_wr_data : r_mem[i_rd_addr_b];

  // Storage array: clear on reset, otherwise single write port.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port A: data held when idle, valid pulses one cycle per strobe.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_rd_data_a <= '0;
      r_rd_vld_a  <= 1'b0;
    end else begin
      r_rd_vld_a <= i_rd_en_a;
      if (i_rd_en_a) begin
        r_rd_data_a <= w_rd_word_a;
      end
    end
  end

  // Read port B: same behaviour as port A, fully independent.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_rd_data_b <= '0;
      r_rd_vld_b  <= 1'b0;
    end else begin
      r_rd_vld_b <= i_rd_en_b;
      if (i_rd_en_b) begin
        r_rd_data_b <= w_rd_word_b;
      end
    end
  end

  // Display scan: prescaler wraps every SCAN_DIV cycles and steps the digit.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_presc <= '0;
      r_dig   <= '0;
    end else if (r_presc == PrescMax) begin
      r_presc <= '0;
      r_dig   <= (r_dig == DigMax) ? '0 : r_dig + DIG_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Zero-extend read port A data to a whole number of nibbles.
  always_comb begin
    w_disp               = '0;
    w_disp[DATA_W-1:0]   = r_rd_data_a;
  end

  // Select the current nibble and drive its active-low digit enable.
  always_comb begin
    w_nib = '0;
    w_an  = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_dig == DIG_W'(i)) begin
        w_nib   = w_disp[i*4 +: 4];
        w_an[i] = 1'b0;
      end
    end
  end

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (o_seg)
  );

  assign o_an        = w_an;
  assign o_rd_data_a = r_rd_data_a;
  assign o_rd_data_b = r_rd_data_b;
  assign o_rd_vld_a  = r_rd_vld_a;
  assign o_rd_vld_b  = r_rd_vld_b;

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed bench for multiport_reg_file: an 8x8 instance with a short scan
// period plus a 12-bit x 16 instance for the wider-word configuration.
module tb_multiport_reg_file;

  // Expected pin patterns (active-low, a..g) for digits used below.
  localparam logic [6:0] PinZero = 7'b0000001;
  localparam logic [6:0] PinE    = 7'b0110000;
  localparam logic [6:0] Pin7    = 7'b0001111;
  localparam logic [6:0] PinC    = 7'b0110001;
  localparam logic [6:0] PinB    = 7'b1100000;
  localparam logic [6:0] PinA    = 7'b0001000;

  logic       ck;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en_a, rd_en_b;
  logic [2:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_vld_a, rd_vld_b;
  logic [6:0] seg;
  logic [1:0] an;

  logic        p2_rst;
  logic        p2_wr_en;
  logic [3:0]  p2_wr_addr;
  logic [11:0] p2_wr_data;
  logic        p2_rd_en_a, p2_rd_en_b;
  logic [3:0]  p2_rd_addr_a, p2_rd_addr_b;
  logic [11:0] p2_rd_data_a, p2_rd_data_b;
  logic        p2_rd_vld_a, p2_rd_vld_b;
  logic [6:0]  p2_seg;
  logic [2:0]  p2_an;

  int n_total = 0;
  int n_bad   = 0;
  int exp_dig;
  logic [2:0] exp_an3;
  logic [6:0] exp_seg3;

  multiport_reg_file #(
    .DATA_W   (8),
    .DEPTH    (8),
    .SCAN_DIV (4)
  ) u_dut (
    .i_ck        (ck),
    .i_rst       (rst),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_rd_en_a   (rd_en_a),
    .i_rd_en_b   (rd_en_b),
    .i_rd_addr_a (rd_addr_a),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_a (rd_data_a),
    .o_rd_data_b (rd_data_b),
    .o_rd_vld_a  (rd_vld_a),
    .o_rd_vld_b  (rd_vld_b),
    .o_seg       (seg),
    .o_an        (an)
  );

  multiport_reg_file #(
    .DATA_W   (12),
    .DEPTH    (16),
    .SCAN_DIV (2)
  ) u_dut_wide (
    .i_ck        (ck),
    .i_rst       (p2_rst),
    .i_wr_en     (p2_wr_en),
    .i_wr_addr   (p2_wr_addr),
    .i_wr_data   (p2_wr_data),
    .i_rd_en_a   (p2_rd_en_a),
    .i_rd_en_b   (p2_rd_en_b),
    .i_rd_addr_a (p2_rd_addr_a),
    .i_rd_addr_b (p2_rd_addr_b),
    .o_rd_data_a (p2_rd_data_a),
    .o_rd_data_b (p2_rd_data_b),
    .o_rd_vld_a  (p2_rd_vld_a),
    .o_rd_vld_b  (p2_rd_vld_b),
    .o_seg       (p2_seg),
    .o_an        (p2_an)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; sampling and driving happen 1 time unit after it.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_en_b = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    p2_rst = 1'b1; p2_wr_en = 1'b0; p2_wr_addr = '0; p2_wr_data = '0;
    p2_rd_en_a = 1'b0; p2_rd_en_b = 1'b0; p2_rd_addr_a = '0; p2_rd_addr_b = '0;

    tick();
    tick();
    chk_eq("rst_data_a", 16'(rd_data_a), 16'h0000);
    chk_eq("rst_data_b", 16'(rd_data_b), 16'h0000);
    chk_eq("rst_vld_a", 16'(rd_vld_a), 16'h0000);
    chk_eq("rst_vld_b", 16'(rd_vld_b), 16'h0000);
    chk_eq("rst_an", 16'(an), 16'h0002);
    chk_eq("rst_seg", 16'(seg), 16'(PinZero));
    rst = 1'b0;

    // Read every address on both ports after reset.
    for (int a = 0; a < 8; a++) begin
      rd_en_a = 1'b1; rd_addr_a = 3'(a);
      rd_en_b = 1'b1; rd_addr_b = 3'(7 - a);
      tick();
      chk_eq("sweep_data_a", 16'(rd_data_a), 16'h0000);
      chk_eq("sweep_data_b", 16'(rd_data_b), 16'h0000);
      chk_eq("sweep_vld_a", 16'(rd_vld_a), 16'h0001);
      chk_eq("sweep_vld_b", 16'(rd_vld_b), 16'h0001);
      chk_eq("sweep_seg", 16'(seg), 16'(PinZero));
    end
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    tick();
    chk_eq("idle_vld_a", 16'(rd_vld_a), 16'h0000);
    chk_eq("idle_vld_b", 16'(rd_vld_b), 16'h0000);

    // Write then read the same word on both ports.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    rd_en_a = 1'b1; rd_addr_a = 3'd3; rd_en_b = 1'b1; rd_addr_b = 3'd3;
    tick();
    chk_eq("wr_rd_a", 16'(rd_data_a), 16'h00A5);
    chk_eq("wr_rd_b", 16'(rd_data_b), 16'h00A5);
    chk_eq("wr_rd_vld_a", 16'(rd_vld_a), 16'h0001);
    chk_eq("wr_rd_vld_b", 16'(rd_vld_b), 16'h0001);

    // A write with the strobe low must not change storage.
    rd_en_b = 1'b0;
    wr_en = 1'b0; wr_addr = 3'd3; wr_data = 8'hFF;
    rd_en_a = 1'b1; rd_addr_a = 3'd3;
    tick();
    chk_eq("no_wr_a", 16'(rd_data_a), 16'h00A5);

    // Bypass on A, old data on B.
    rd_en_a = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h11;
    tick();
    wr_addr = 3'd5; wr_data = 8'h3C;
    rd_en_a = 1'b1; rd_addr_a = 3'd5;
    rd_en_b = 1'b1; rd_addr_b = 3'd4;
    tick();
    chk_eq("byp_a", 16'(rd_data_a), 16'h003C);
    chk_eq("old_b", 16'(rd_data_b), 16'h0011);
    wr_en = 1'b0; wr_data = 8'h00; rd_en_a = 1'b0; rd_en_b = 1'b0;
    tick();
    chk_eq("hold_a", 16'(rd_data_a), 16'h003C);
    chk_eq("hold_b", 16'(rd_data_b), 16'h0011);
    chk_eq("hold_vld_a", 16'(rd_vld_a), 16'h0000);

    // Both ports bypass on the same address.
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h99;
    rd_en_a = 1'b1; rd_addr_a = 3'd6; rd_en_b = 1'b1; rd_addr_b = 3'd6;
    tick();
    chk_eq("byp2_a", 16'(rd_data_a), 16'h0099);
    chk_eq("byp2_b", 16'(rd_data_b), 16'h0099);
    wr_en = 1'b0; rd_en_b = 1'b0; rd_addr_a = 3'd5;
    tick();
    chk_eq("stored_5", 16'(rd_data_a), 16'h003C);

    // Scan of 0x7E from a fresh reset: 4 cycles per digit.
    rd_en_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h7E;
    rd_en_a = 1'b1; rd_addr_a = 3'd1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      wr_en = 1'b0; rd_en_a = 1'b0;
      exp_dig = (k / 4) % 2;
      chk_eq("scan_an", 16'(an), (exp_dig == 1) ? 16'h0001 : 16'h0002);
      chk_eq("scan_seg", 16'(seg), (exp_dig == 1) ? 16'(Pin7) : 16'(PinE));
    end
    chk_eq("scan_data", 16'(rd_data_a), 16'h007E);

    // Reset while on digit 1 with a coinciding write and reads.
    tick();
    chk_eq("pre_rst_an", 16'(an), 16'h0001);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h55;
    rd_en_a = 1'b1; rd_addr_a = 3'd2; rd_en_b = 1'b1; rd_addr_b = 3'd2;
    tick();
    chk_eq("mid_rst_an", 16'(an), 16'h0002);
    chk_eq("mid_rst_seg", 16'(seg), 16'(PinZero));
    chk_eq("mid_rst_vld_a", 16'(rd_vld_a), 16'h0000);
    chk_eq("mid_rst_vld_b", 16'(rd_vld_b), 16'h0000);
    chk_eq("mid_rst_data_a", 16'(rd_data_a), 16'h0000);
    rst = 1'b0; wr_en = 1'b0; rd_en_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      rd_en_a = 1'b0;
      if (k == 1) begin
        chk_eq("rst_word2", 16'(rd_data_a), 16'h0000);
        chk_eq("rst_word2_vld", 16'(rd_vld_a), 16'h0001);
      end
      chk_eq("restart_an", 16'(an), (k >= 4) ? 16'h0001 : 16'h0002);
    end

    // Wide instance: 3 digits, top address, 2 cycles per digit.
    tick();
    p2_rst = 1'b0;
    p2_wr_en = 1'b1; p2_wr_addr = 4'd15; p2_wr_data = 12'hABC;
    p2_rd_en_a = 1'b1; p2_rd_addr_a = 4'd15;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        chk_eq("wide_byp_a", 16'(p2_rd_data_a), 16'h0ABC);
        chk_eq("wide_vld_a", 16'(p2_rd_vld_a), 16'h0001);
        p2_wr_en = 1'b0; p2_rd_en_a = 1'b0;
        p2_rd_en_b = 1'b1; p2_rd_addr_b = 4'd15;
      end
      if (k == 2) begin
        chk_eq("wide_rd_b", 16'(p2_rd_data_b), 16'h0ABC);
        chk_eq("wide_vld_b", 16'(p2_rd_vld_b), 16'h0001);
        p2_rd_en_b = 1'b0;
      end
      exp_dig = (k / 2) % 3;
      case (exp_dig)
        0:       begin exp_an3 = 3'b110; exp_seg3 = PinC; end
        1:       begin exp_an3 = 3'b101; exp_seg3 = PinB; end
        default: begin exp_an3 = 3'b011; exp_seg3 = PinA; end
      endcase
      chk_eq("wide_an", 16'(p2_an), 16'(exp_an3));
      chk_eq("wide_seg", 16'(p2_seg), 16'(exp_seg3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multiport_reg_file.md
MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the word width in bits, legal range 4..16.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of words; it SHALL be a power of two, 2..64.
REQ-003 Parameter SCAN_DIV, default 16, SHALL set the ck cycles per display digit, minimum 2.
REQ-004 Derived constants SHALL be ADDR_W = clog2(DEPTH) and DIGITS = ceil(DATA_W/4).
REQ-005 Port ck, input, 1 bit: the single clock, rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 Port wr_en, input, 1 bit: write strobe.
REQ-008 Port wr_addr, input, ADDR_W bits: write address.
REQ-009 Port wr_data, input, DATA_W bits: write data.
REQ-010 Ports rd_en_a and rd_en_b, input, 1 bit each: read strobes for ports A and B.
REQ-011 Ports rd_addr_a and rd_addr_b, input, ADDR_W bits each: read addresses.
REQ-012 Ports rd_data_a and rd_data_b, output, DATA_W bits each: registered read data.
REQ-013 Ports rd_vld_a and rd_vld_b, output, 1 bit each: read-data-valid pulses.
REQ-014 Port seg, output, 7 bits: segments a..g, where seg[6]=a and seg[0]=g, active-low.
REQ-015 Port an, output, DIGITS bits: digit enables, active-low, one-hot; an[0] is the least significant nibble.

Function
REQ-016 When wr_en=1 at a rising edge of ck, word[wr_addr] SHALL take wr_data; when wr_en=0, storage SHALL be unchanged.
REQ-017 When rd_en_x=1 at an edge, rd_data_x SHALL take word[rd_addr_x] at that edge (latency 1); when rd_en_x=0, rd_data_x SHALL hold its value.
REQ-018 rd_vld_x SHALL be 1 for exactly the cycle following each edge where rd_en_x=1, and 0 otherwise.
REQ-019 Bypass: when rd_en_x=1, wr_en=1 and rd_addr_x=wr_addr at the same edge, rd_data_x SHALL take wr_data (new data), not the old contents.
REQ-020 Ports A and B SHALL operate independently; both may read the same address at the same edge, and both may bypass.
REQ-021 Display source SHALL be rd_data_a, zero-extended to 4*DIGITS bits.
REQ-022 Prescaler SHALL count 0..SCAN_DIV-1 and then wrap to 0; the digit index SHALL advance by one on each wrap, going 0..DIGITS-1 and then back to 0.
REQ-023 an SHALL drive 0 only at the current digit index; seg SHALL be the hex decode of nibble[digit index] (0-F, standard patterns; 0=1111110 before inversion, so on the pins 0000001).
REQ-024 seg SHALL be combinational from the digit index and rd_data_a, so a new read value appears on the current digit in the same cycle rd_data_a changes.

Reset
REQ-025 When rst=1 at an edge, all words, rd_data_a/b, rd_vld_a/b, the prescaler and the digit index SHALL become 0.
REQ-026 rst SHALL dominate: a coinciding wr_en or rd_en SHALL have no effect, and rd_vld SHALL be 0 in the cycle after.
REQ-027 After reset, outputs SHALL be an = all ones except an[0]=0, and seg = 0000001 (digit "0").
REQ-028 Reset asserted mid-scan SHALL restart the scan at digit 0 with the prescaler at 0.

Structure
REQ-029 A shared package SHALL hold the hex-to-segment constant table and the default values of DATA_W, DEPTH and SCAN_DIV.
REQ-030 One sub-module, hex7seg (4-bit in, 7-bit active-low out), SHALL do the segment decode; it SHALL be instantiated once.
REQ-031 Storage SHALL be an inferred register array with no tri-states; read muxing SHALL be done with multiplexers.

Verification
REQ-032 Reset then read all addresses on both ports -> every rd_data=0, rd_vld pulses one cycle after each rd_en, an[0]=0, seg=0000001.
REQ-033 Write 0xA5 to addr 3, then read A@3 and B@3 on the next edge -> both rd_data=0xA5 one cycle later with rd_vld_a=rd_vld_b=1.
REQ-034 Same edge: wr_en with addr 5 / 0x3C, rd_en_a with addr 5 -> rd_data_a=0x3C next cycle (bypass); rd_en_b with addr 4 -> old word[4].
REQ-035 rd_data_a=0x7E, SCAN_DIV=4 -> an=10 for 4 cycles with seg=decode(E), then an=01 for 4 cycles with seg=decode(7), repeating.
REQ-036 Assert rst while the digit index is 1 and wr_en=1 with addr 2 -> word[2] stays 0, an returns to digit 0, prescaler restarts at 0.
REQ-037 Parameter sweep (DATA_W=12, DEPTH=16) -> DIGITS=3, addr 15 writes/reads correctly, an cycles through 3 digits.
